// File: rtl/rs232_deser.sv
// rs232_deser -- 8N1 RS-232 receiver feeding a downstream RX FIFO.
//
// Ports
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   rx             in   serial line, asynchronous to clk, idles high
//   rx_fifo_data   out  received byte, valid while rx_fifo_wr_en is high
//   rx_fifo_wr_en  out  one-cycle FIFO write strobe
//   rx_fifo_full   in   FIFO full; blocks the write and raises overrun
//   frame_err      out  one-cycle pulse when the stop bit samples low
//   overrun        out  one-cycle pulse when a good byte is dropped (FIFO full)
//   busy           out  high whenever the receiver is not idle
//
// P_CLKS_PER_BIT must match the transmitter and be at least 4.
module rs232_deser #(
  parameter int P_CLKS_PER_BIT = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_fifo_data,
  output logic       rx_fifo_wr_en,
  input  logic       rx_fifo_full,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int HALF = P_CLKS_PER_BIT / 2 - 1;
  localparam int CW   = (P_CLKS_PER_BIT > 2) ? $clog2(P_CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] C_HALF = CW'(HALF);
  localparam logic [CW-1:0] C_LAST = CW'(P_CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_SHIFT = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_sync1, r_sync2;
  logic            w_rx_s;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;

  logic w_cnt_inc, w_sample, w_bit_inc, w_wr, w_ferr, w_ovr;

  // Two-FF synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end
  assign w_rx_s = r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_inc   = 1'b0;
    w_sample    = 1'b0;
    w_bit_inc   = 1'b0;
    w_wr        = 1'b0;
    w_ferr      = 1'b0;
    w_ovr       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) w_state_nxt = S_START;
      end
      S_START: begin
        // Re-check the line half a bit in: a high here was a glitch.
        if (r_cnt == C_HALF) w_state_nxt = w_rx_s ? S_IDLE : S_SHIFT;
        else                 w_cnt_inc   = 1'b1;
      end
      S_SHIFT: begin
        // Counting a full bit from the start-bit centre lands on each data-bit centre.
        if (r_cnt == C_LAST) begin
          w_sample = 1'b1;
          if (r_bit_cnt == 3'd7) w_state_nxt = S_STOP;
          else                   w_bit_inc   = 1'b1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_STOP: begin
        // Leaving at the stop-bit centre lets a start bit follow with no idle gap.
        if (r_cnt == C_LAST) begin
          if (w_rx_s) begin
            if (rx_fifo_full) w_ovr = 1'b1;
            else              w_wr  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_BREAK: begin
        // Hold off until the line returns high so a held-low line is not a start bit.
        if (w_rx_s) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The counter only advances while waiting mid-state; any sample or state
  // change (and idling in S_IDLE/S_BREAK) clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      r_cnt <= w_cnt_inc ? r_cnt + 1'b1 : '0;
      if (r_state == S_IDLE) r_bit_cnt <= '0;
      else if (w_bit_inc)    r_bit_cnt <= r_bit_cnt + 3'd1;
      if (w_sample) r_shift <= {w_rx_s, r_shift[7:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_fifo_data  <= '0;
      rx_fifo_wr_en <= 1'b0;
      frame_err     <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      rx_fifo_wr_en <= w_wr;
      frame_err     <= w_ferr;
      overrun       <= w_ovr;
      if (w_wr) rx_fifo_data <= r_shift;
    end
  end

  assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_rs232_deser.sv
module tb_rs232_deser;
  localparam int P    = 20;
  localparam int HALF = P / 2 - 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       full = 1'b0;
  logic [7:0] data;
  logic       wr_en, ferr, ovr, busy;

  rs232_deser #(.P_CLKS_PER_BIT(P)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .rx_fifo_data(data), .rx_fifo_wr_en(wr_en), .rx_fifo_full(full),
    .frame_err(ferr), .overrun(ovr), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed traffic
  logic [7:0] got_q[$];
  int         got_cyc[$];
  int         n_ferr = 0, n_ovr = 0, n_multi = 0;

  always @(negedge clk) begin
    if (wr_en) begin
      got_q.push_back(data);
      got_cyc.push_back(cyc);
    end
    if (ferr) n_ferr++;
    if (ovr)  n_ovr++;
    if (int'(wr_en) + int'(ferr) + int'(ovr) > 1) n_multi++;
  end

  // Reference model: what each frame should produce
  logic [7:0] exp_q[$];
  int         exp_ferr = 0, exp_ovr = 0;
  int         total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic bit_time(input logic b);
    rx = b;
    repeat (P) @(negedge clk);
  endtask

  // Sends one frame starting at a negedge; returns the cycle count at the
  // negedge where the start bit was driven.
  task automatic send(input logic [7:0] d, input logic stop_ok, output int c0);
    c0 = cyc;
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
    bit_time(stop_ok);
    if (!stop_ok)  exp_ferr++;
    else if (full) exp_ovr++;
    else           exp_q.push_back(d);
  endtask

  task automatic settle_and_check(input string tag);
    rx = 1'b1;
    repeat (2 * P) @(negedge clk);
    chk({tag, ".count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, ".data"}, got_q[i], exp_q[i]);
    chk({tag, ".ferr"}, n_ferr, exp_ferr);
    chk({tag, ".ovr"}, n_ovr, exp_ovr);
    chk({tag, ".excl"}, n_multi, 0);
    chk({tag, ".idle"}, busy, 1'b0);
    got_q.delete(); got_cyc.delete(); exp_q.delete();
    n_ferr = 0; n_ovr = 0; n_multi = 0; exp_ferr = 0; exp_ovr = 0;
  endtask

  initial begin
    int c0, c1;
    logic [7:0] lb[5] = '{8'h55, 8'hA5, 8'h00, 8'hFF, 8'h80};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst.outs", {data, wr_en, ferr, ovr, busy}, 12'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst.busy", busy, 1'b0);

    // Directed bytes with an idle bit between frames; latency on the first.
    for (int i = 0; i < 5; i++) begin
      send(lb[i], 1'b1, c0);
      if (i == 0) begin
        // start driven before edge c0+1; strobe set by edge c0+1+3+HALF+9P
        chk("lat.present", got_cyc.size(), 1);
        if (got_cyc.size() > 0) chk("lat.cycle", got_cyc[0], c0 + 4 + HALF + 9 * P);
      end
      bit_time(1'b1);
    end
    settle_and_check("loop");

    // Back-to-back, zero idle gap
    send(8'h12, 1'b1, c0);
    send(8'h34, 1'b1, c1);
    settle_and_check_b2b: begin
      chk("b2b.gap.n", got_cyc.size(), 2);
      if (got_cyc.size() == 2) chk("b2b.gap", got_cyc[1] - got_cyc[0], 10 * P);
    end
    settle_and_check("b2b");

    // Glitch: 5 clocks low
    rx = 1'b0;
    repeat (3) @(negedge clk);
    chk("glitch.busy", busy, 1'b1);
    repeat (2) @(negedge clk);
    settle_and_check("glitch");

    // Framing error with a break, then recovery
    send(8'h3C, 1'b0, c0);
    repeat (3) bit_time(1'b0);
    chk("brk.busy", busy, 1'b1);
    bit_time(1'b1);
    send(8'hC3, 1'b1, c0);
    settle_and_check("frame");

    // Overrun, then recovery
    full = 1'b1;
    send(8'h7E, 1'b1, c0);
    full = 1'b0;
    bit_time(1'b1);
    send(8'h81, 1'b1, c0);
    settle_and_check("ovr");

    // Reset during bit 4 of 0x99
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(1'(8'h99 >> i));
    rx = 1'b1;
    repeat (P / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst.outs", {data, wr_en, ferr, ovr, busy}, 12'h0);
    repeat (P) @(negedge clk);
    rst_n = 1'b1;
    bit_time(1'b1);
    send(8'h42, 1'b1, c0);
    settle_and_check("midrst");

    // Random frames, random gaps and FIFO-full
    for (int i = 0; i < 8; i++) begin
      full = ($urandom_range(0, 3) == 0);
      send(8'($urandom), 1'b1, c0);
      full = 1'b0;
      repeat ($urandom_range(0, P)) @(negedge clk);
    end
    settle_and_check("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
